// File: rtl/breathe_pkg.sv
// Shared types and constants for the breathing-LED duty generator.
// The state encoding is exported on the phase port, so the values are fixed.
package breathe_pkg;

   localparam int DUTY_W       = 8;
   localparam int DEF_MAX_DUTY = 255;

   typedef enum logic [1:0] {
      RISE    = 2'd0,
      HOLD_HI = 2'd1,
      FALL    = 2'd2,
      HOLD_LO = 2'd3
   } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV enabled cycles.
// A low en freezes the count, so a paused ramp resumes mid-interval.
module tick_gen #(
   parameter int TICK_DIV = 196078
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/breathe_drv.sv
// Breathing duty source: triangular ramp with dwell at both ends, paced by tick_gen.
// duty2 is either the complement of duty1 or a copy of it, chosen by mode.
module breathe_drv
   import breathe_pkg::*;
#(
   parameter int TICK_DIV   = 196078,
   parameter int STEP       = 1,
   parameter int HOLD_TICKS = 64,
   parameter int MAX_DUTY   = DEF_MAX_DUTY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   output logic [DUTY_W-1:0] duty1,
   output logic [DUTY_W-1:0] duty2,
   output logic              upd,
   output logic [1:0]        phase
);

   localparam int                HC_W      = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [HC_W-1:0]   HOLD_LAST = HC_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);
   localparam logic [DUTY_W:0]   MAX9      = (DUTY_W + 1)'(MAX_DUTY);
   localparam logic [DUTY_W:0]   STEP9     = (DUTY_W + 1)'(STEP);
   localparam logic [DUTY_W-1:0] MAX8      = DUTY_W'(MAX_DUTY);
   localparam state_t            AFTER_TOP = (HOLD_TICKS == 0) ? FALL : HOLD_HI;
   localparam state_t            AFTER_BOT = (HOLD_TICKS == 0) ? RISE : HOLD_LO;

   logic              tick;
   state_t            state_reg, state_next;
   logic [HC_W-1:0]   hold_reg, hold_next;
   logic [DUTY_W-1:0] duty_next, duty2_next;
   logic [DUTY_W:0]   sum9, dif9;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   // 9-bit sum/difference: the carry/borrow bit decides saturation at the ends.
   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      duty_next  = duty1;
      sum9       = {1'b0, duty1} + STEP9;
      dif9       = {1'b0, duty1} - STEP9;
      if (tick) begin
         case (state_reg)
            RISE: begin
               if (sum9 >= MAX9) begin
                  duty_next  = MAX8;
                  state_next = AFTER_TOP;
               end else begin
                  duty_next = sum9[DUTY_W-1:0];
               end
            end
            HOLD_HI: begin
               if (hold_reg == HOLD_LAST) begin
                  hold_next  = '0;
                  state_next = FALL;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
            FALL: begin
               if (dif9[DUTY_W] || (dif9 == '0)) begin
                  duty_next  = '0;
                  state_next = AFTER_BOT;
               end else begin
                  duty_next = dif9[DUTY_W-1:0];
               end
            end
            HOLD_LO: begin
               if (hold_reg == HOLD_LAST) begin
                  hold_next  = '0;
                  state_next = RISE;
               end else begin
                  hold_next = hold_reg + 1'b1;
               end
            end
            default: state_next = RISE;
         endcase
      end
      duty2_next = mode ? duty_next : (MAX8 - duty_next);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RISE;
         hold_reg  <= '0;
         duty1     <= '0;
         duty2     <= MAX8;
         upd       <= 1'b0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         duty1     <= duty_next;
         duty2     <= duty2_next;
         upd       <= (duty_next != duty1);
      end
   end

   assign phase = state_reg;

endmodule

// File: tb/tb_breathe_drv.sv
// Bench for breathe_drv: two instances (with and without dwell) checked against
// a per-tick level profile built from the ramp rules.
module tb_breathe_drv;

   localparam int TD = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1, en_a = 1'b0, mode_a = 1'b0;
   logic       rst_b = 1'b1, en_b = 1'b0, mode_b = 1'b0;
   logic [7:0] duty1_a, duty2_a, duty1_b, duty2_b;
   logic       upd_a, upd_b;
   logic [1:0] phase_a, phase_b;

   breathe_drv #(.TICK_DIV(TD), .STEP(64), .HOLD_TICKS(2), .MAX_DUTY(255)) dut_a (
      .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a),
      .duty1(duty1_a), .duty2(duty2_a), .upd(upd_a), .phase(phase_a)
   );

   breathe_drv #(.TICK_DIV(TD), .STEP(100), .HOLD_TICKS(0), .MAX_DUTY(255)) dut_b (
      .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b),
      .duty1(duty1_b), .duty2(duty2_b), .upd(upd_b), .phase(phase_b)
   );

   int total = 0;
   int bad   = 0;

   // Profile: the (duty, phase) visible after each successive tick of one period.
   int prof_d[2][64];
   int prof_p[2][64];
   int plen[2];
   int m_d[2], m_d2[2], m_ph[2], m_upd[2], m_ecnt[2], m_tk[2];

   function automatic void build(input int i, input int step, input int hold);
      int v;
      int n;
      v = 0;
      n = 0;
      do begin
         v = (v + step > 255) ? 255 : v + step;
         prof_d[i][n] = v;
         prof_p[i][n] = (v < 255) ? 0 : ((hold > 0) ? 1 : 2);
         n++;
      end while (v < 255);
      for (int h = 0; h < hold; h++) begin
         prof_d[i][n] = 255;
         prof_p[i][n] = (h == hold - 1) ? 2 : 1;
         n++;
      end
      do begin
         v = (v - step < 0) ? 0 : v - step;
         prof_d[i][n] = v;
         prof_p[i][n] = (v > 0) ? 2 : ((hold > 0) ? 3 : 0);
         n++;
      end while (v > 0);
      for (int h = 0; h < hold; h++) begin
         prof_d[i][n] = 0;
         prof_p[i][n] = (h == hold - 1) ? 0 : 3;
         n++;
      end
      plen[i] = n;
   endfunction

   task automatic model(input int i, input logic r, input logic e, input logic m);
      int k;
      if (r) begin
         m_d[i] = 0; m_d2[i] = 255; m_ph[i] = 0; m_upd[i] = 0; m_ecnt[i] = 0; m_tk[i] = 0;
      end else begin
         m_upd[i] = 0;
         if (e) begin
            m_ecnt[i]++;
            if (m_ecnt[i] % TD == 0) begin
               k        = m_tk[i] % plen[i];
               m_upd[i] = (prof_d[i][k] != m_d[i]) ? 1 : 0;
               m_d[i]   = prof_d[i][k];
               m_ph[i]  = prof_p[i][k];
               m_tk[i]++;
            end
         end
         m_d2[i] = m ? m_d[i] : 255 - m_d[i];
      end
   endtask

   // Advance one clock; model sees the inputs that the DUT sampled.
   task automatic cyc();
      @(posedge clk);
      model(0, rst_a, en_a, mode_a);
      model(1, rst_b, en_b, mode_b);
      #1;
   endtask

   task automatic test_reset();
      rst_a = 1'b1; rst_b = 1'b1;
      cyc(); cyc();
      total += 4;
      if (duty1_a !== 8'd0)   begin bad++; $display("FAIL reset_duty1 got=%0d exp=0", duty1_a); end
      if (duty2_a !== 8'd255) begin bad++; $display("FAIL reset_duty2 got=%0d exp=255", duty2_a); end
      if (phase_a !== 2'd0)   begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase_a); end
      if (upd_a !== 1'b0)     begin bad++; $display("FAIL reset_upd got=%0b exp=0", upd_a); end
      rst_a = 1'b0;
   endtask

   task automatic test_ramp();
      int pulses;
      pulses = 0;
      en_a = 1'b1; mode_a = 1'b0;
      for (int c = 0; c < 13 * TD; c++) begin
         cyc();
         if (upd_a === 1'b1) pulses++;
         total += 4;
         if (duty1_a !== 8'(m_d[0]))  begin bad++; $display("FAIL ramp_duty1 cyc=%0d got=%0d exp=%0d", c, duty1_a, m_d[0]); end
         if (duty2_a !== 8'(m_d2[0])) begin bad++; $display("FAIL ramp_duty2 cyc=%0d got=%0d exp=%0d", c, duty2_a, m_d2[0]); end
         if (phase_a !== 2'(m_ph[0])) begin bad++; $display("FAIL ramp_phase cyc=%0d got=%0d exp=%0d", c, phase_a, m_ph[0]); end
         if (upd_a !== 1'(m_upd[0]))  begin bad++; $display("FAIL ramp_upd cyc=%0d got=%0b exp=%0d", c, upd_a, m_upd[0]); end
      end
      total += 3;
      if (pulses != 9)         begin bad++; $display("FAIL ramp_pulses got=%0d exp=9", pulses); end
      if (duty1_a !== 8'd64)   begin bad++; $display("FAIL ramp_wrap_duty got=%0d exp=64", duty1_a); end
      if (phase_a !== 2'd0)    begin bad++; $display("FAIL ramp_wrap_phase got=%0d exp=0", phase_a); end
   endtask

   task automatic test_freeze();
      int n;
      n = 0;
      while (m_d[0] != 128 && n < 20) begin cyc(); n++; end
      total++;
      if (duty1_a !== 8'd128) begin bad++; $display("FAIL freeze_reach got=%0d exp=128", duty1_a); end
      cyc(); cyc();
      en_a = 1'b0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         total += 3;
         if (duty1_a !== 8'd128) begin bad++; $display("FAIL freeze_duty1 cyc=%0d got=%0d exp=128", c, duty1_a); end
         if (phase_a !== 2'd0)   begin bad++; $display("FAIL freeze_phase cyc=%0d got=%0d exp=0", c, phase_a); end
         if (upd_a !== 1'b0)     begin bad++; $display("FAIL freeze_upd cyc=%0d got=%0b exp=0", c, upd_a); end
      end
      en_a = 1'b1;
      n = 0;
      do begin cyc(); n++; end while (upd_a !== 1'b1 && n < 8);
      total += 2;
      if (n != 2)             begin bad++; $display("FAIL resume_latency got=%0d exp=2", n); end
      if (duty1_a !== 8'd192) begin bad++; $display("FAIL resume_duty1 got=%0d exp=192", duty1_a); end
   endtask

   task automatic test_mode();
      rst_a = 1'b1; cyc(); rst_a = 1'b0;
      en_a = 1'b1; mode_a = 1'b0;
      repeat (TD) cyc();
      en_a = 1'b0;
      total += 2;
      if (duty1_a !== 8'd64)  begin bad++; $display("FAIL mode_pre_duty1 got=%0d exp=64", duty1_a); end
      if (duty2_a !== 8'd191) begin bad++; $display("FAIL mode_pre_duty2 got=%0d exp=191", duty2_a); end
      mode_a = 1'b1;
      #1;
      total++;
      if (duty2_a !== 8'd191) begin bad++; $display("FAIL mode_early got=%0d exp=191", duty2_a); end
      cyc();
      total += 2;
      if (duty2_a !== 8'd64)  begin bad++; $display("FAIL mode_inphase got=%0d exp=64", duty2_a); end
      if (upd_a !== 1'b0)     begin bad++; $display("FAIL mode_upd got=%0b exp=0", upd_a); end
      mode_a = 1'b0;
      cyc();
      total += 2;
      if (duty2_a !== 8'd191) begin bad++; $display("FAIL mode_restore got=%0d exp=191", duty2_a); end
      if (upd_a !== 1'b0)     begin bad++; $display("FAIL mode_restore_upd got=%0b exp=0", upd_a); end
   endtask

   task automatic test_nohold();
      int seq[$];
      int exp_seq[7];
      exp_seq = '{100, 200, 255, 155, 55, 0, 100};
      rst_b = 1'b0; en_b = 1'b1; mode_b = 1'b0;
      for (int c = 0; c < 7 * TD; c++) begin
         cyc();
         if (upd_b === 1'b1) seq.push_back(int'(duty1_b));
         total += 3;
         if (duty1_b !== 8'(m_d[1]))  begin bad++; $display("FAIL nohold_duty1 cyc=%0d got=%0d exp=%0d", c, duty1_b, m_d[1]); end
         if (duty2_b !== 8'(m_d2[1])) begin bad++; $display("FAIL nohold_duty2 cyc=%0d got=%0d exp=%0d", c, duty2_b, m_d2[1]); end
         if (phase_b[0] !== 1'b0)     begin bad++; $display("FAIL nohold_phase cyc=%0d got=%0d exp=0or2", c, phase_b); end
      end
      en_b = 1'b0;
      total++;
      if (seq.size() != 7) begin
         bad++; $display("FAIL nohold_count got=%0d exp=7", seq.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            total++;
            if (seq[k] != exp_seq[k]) begin bad++; $display("FAIL nohold_seq idx=%0d got=%0d exp=%0d", k, seq[k], exp_seq[k]); end
         end
      end
   endtask

   task automatic test_async_reset();
      int n;
      rst_a = 1'b1; cyc(); rst_a = 1'b0;
      en_a = 1'b1; mode_a = 1'b0;
      n = 0;
      while (!(m_d[0] == 127 && m_ph[0] == 2) && n < 100) begin cyc(); n++; end
      cyc();
      total++;
      if (duty1_a !== 8'd127) begin bad++; $display("FAIL arst_reach got=%0d exp=127", duty1_a); end
      #3 rst_a = 1'b1;
      #1;
      model(0, 1'b1, en_a, mode_a);
      total += 4;
      if (duty1_a !== 8'd0)   begin bad++; $display("FAIL arst_duty1 got=%0d exp=0", duty1_a); end
      if (duty2_a !== 8'd255) begin bad++; $display("FAIL arst_duty2 got=%0d exp=255", duty2_a); end
      if (phase_a !== 2'd0)   begin bad++; $display("FAIL arst_phase got=%0d exp=0", phase_a); end
      if (upd_a !== 1'b0)     begin bad++; $display("FAIL arst_upd got=%0b exp=0", upd_a); end
      cyc();
      rst_a = 1'b0;
      for (int c = 1; c <= TD; c++) begin
         cyc();
         total += 2;
         if (upd_a !== ((c == TD) ? 1'b1 : 1'b0)) begin bad++; $display("FAIL arst_step_upd cyc=%0d got=%0b", c, upd_a); end
         if (duty1_a !== ((c == TD) ? 8'd64 : 8'd0)) begin bad++; $display("FAIL arst_step_duty cyc=%0d got=%0d", c, duty1_a); end
      end
   endtask

   task automatic test_random();
      rst_a = 1'b1; cyc(); rst_a = 1'b0;
      for (int c = 0; c < 600; c++) begin
         en_a   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) mode_a = ~mode_a;
         rst_a  = ($urandom_range(0, 149) == 0);
         cyc();
         total += 4;
         if (duty1_a !== 8'(m_d[0]))  begin bad++; $display("FAIL rand_duty1 cyc=%0d got=%0d exp=%0d", c, duty1_a, m_d[0]); end
         if (duty2_a !== 8'(m_d2[0])) begin bad++; $display("FAIL rand_duty2 cyc=%0d got=%0d exp=%0d", c, duty2_a, m_d2[0]); end
         if (phase_a !== 2'(m_ph[0])) begin bad++; $display("FAIL rand_phase cyc=%0d got=%0d exp=%0d", c, phase_a, m_ph[0]); end
         if (upd_a !== 1'(m_upd[0]))  begin bad++; $display("FAIL rand_upd cyc=%0d got=%0b exp=%0d", c, upd_a, m_upd[0]); end
      end
      rst_a = 1'b0;
   endtask

   initial begin
      build(0, 64, 2);
      build(1, 100, 0);
      model(0, 1'b1, 1'b0, 1'b0);
      model(1, 1'b1, 1'b0, 1'b0);
      test_reset();
      test_ramp();
      test_freeze();
      test_mode();
      test_nohold();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
